// File: rtl/sc_frog_position_register.sv
`default_nettype none
// ============================================================================
// sc_frog_position_register
// Frog row/column register with one-hot matrix image, hop counter and goal pulse.
// Revision: 1.0
// ============================================================================
module sc_frog_position_register #(
   parameter int ROWS      = 8,
   parameter int COLS      = 8,
   parameter int START_ROW = 0,
   parameter int START_COL = 3
) (
   input  logic                     SC_FROGREGISTER_CLOCK_50,
   input  logic                     SC_FROGREGISTER_RESET_InLow,
   input  logic                     SC_FROGREGISTER_clear_InLow,
   input  logic                     SC_FROGREGISTER_load0_InLow,
   input  logic                     SC_FROGREGISTER_load1_InLow,
   input  logic [1:0]               SC_FROGREGISTER_shiftselection_In,
   output logic [ROWS*COLS-1:0]     SC_FROGREGISTER_matrix_Out,
   output logic [$clog2(ROWS)-1:0]  SC_FROGREGISTER_row_Out,
   output logic [$clog2(COLS)-1:0]  SC_FROGREGISTER_col_Out,
   output logic                     SC_FROGREGISTER_bottomsidecomparator_OutLow,
   output logic                     SC_FROGREGISTER_goal_OutHigh,
   output logic [7:0]               SC_FROGREGISTER_hops_Out
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   localparam logic [RW-1:0] c_START_ROW = RW'(START_ROW);
   localparam logic [CW-1:0] c_START_COL = CW'(START_COL);
   localparam logic [RW-1:0] c_TOP_ROW   = RW'(ROWS - 1);
   localparam logic [CW-1:0] c_LEFT_COL  = CW'(COLS - 1);
   localparam logic [1:0]    c_SHIFT_LEFT  = 2'b01;
   localparam logic [1:0]    c_SHIFT_RIGHT = 2'b10;

   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic [7:0]    r_hops;
   logic          r_goal;

   logic [RW-1:0] w_rowNext;
   logic [CW-1:0] w_colNext;
   logic          w_clear;
   logic          w_move;

   // Priority decode: clear > up > down > shift; blocked moves leave w_move low.
   always_comb begin
      w_rowNext = r_row;
      w_colNext = r_col;
      w_clear   = 1'b0;
      w_move    = 1'b0;
      if (!SC_FROGREGISTER_clear_InLow) begin
         w_clear = 1'b1;
      end else if (!SC_FROGREGISTER_load0_InLow) begin
         if (r_row != c_TOP_ROW) begin
            w_rowNext = r_row + RW'(1);
            w_move    = 1'b1;
         end
      end else if (!SC_FROGREGISTER_load1_InLow) begin
         if (r_row != '0) begin
            w_rowNext = r_row - RW'(1);
            w_move    = 1'b1;
         end
      end else begin
         case (SC_FROGREGISTER_shiftselection_In)
            c_SHIFT_LEFT: begin
               if (r_col != c_LEFT_COL) begin
                  w_colNext = r_col + CW'(1);
                  w_move    = 1'b1;
               end
            end
            c_SHIFT_RIGHT: begin
               if (r_col != '0) begin
                  w_colNext = r_col - CW'(1);
                  w_move    = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge SC_FROGREGISTER_CLOCK_50 or negedge SC_FROGREGISTER_RESET_InLow) begin
      if (!SC_FROGREGISTER_RESET_InLow) begin
         r_row  <= c_START_ROW;
         r_col  <= c_START_COL;
         r_hops <= 8'd0;
         r_goal <= 1'b0;
      end else if (w_clear) begin
         r_row  <= c_START_ROW;
         r_col  <= c_START_COL;
         r_hops <= 8'd0;
         r_goal <= 1'b0;
      end else begin
         r_row  <= w_rowNext;
         r_col  <= w_colNext;
         if (w_move && (r_hops != 8'hFF)) begin
            r_hops <= r_hops + 8'd1;
         end
         // Only an accepted up-move can reach the top row from below it.
         r_goal <= (w_rowNext == c_TOP_ROW) && (r_row != c_TOP_ROW);
      end
   end

   generate
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         for (genvar c = 0; c < COLS; c++) begin : g_col
            assign SC_FROGREGISTER_matrix_Out[r*COLS + c] =
               (r_row == RW'(r)) && (r_col == CW'(c));
         end
      end
   endgenerate

   assign SC_FROGREGISTER_row_Out                     = r_row;
   assign SC_FROGREGISTER_col_Out                     = r_col;
   assign SC_FROGREGISTER_bottomsidecomparator_OutLow = (r_row != '0);
   assign SC_FROGREGISTER_goal_OutHigh                = r_goal;
   assign SC_FROGREGISTER_hops_Out                    = r_hops;

endmodule
`default_nettype wire

// File: tb/tb_sc_frog_position_register.sv
`default_nettype none
// ============================================================================
// tb_sc_frog_position_register
// Directed self-checking bench for the frog position register.
// Revision: 1.0
// ============================================================================
module tb_sc_frog_position_register;

   logic        clk;
   logic        rstN;
   logic        clearN;
   logic        load0N;
   logic        load1N;
   logic [1:0]  shiftSel;
   logic [63:0] matrix;
   logic [2:0]  row;
   logic [2:0]  col;
   logic        bottom;
   logic        goal;
   logic [7:0]  hops;

   int vectors;
   int miscompares;

   sc_frog_position_register #(
      .ROWS(8), .COLS(8), .START_ROW(0), .START_COL(3)
   ) dut (
      .SC_FROGREGISTER_CLOCK_50                    (clk),
      .SC_FROGREGISTER_RESET_InLow                 (rstN),
      .SC_FROGREGISTER_clear_InLow                 (clearN),
      .SC_FROGREGISTER_load0_InLow                 (load0N),
      .SC_FROGREGISTER_load1_InLow                 (load1N),
      .SC_FROGREGISTER_shiftselection_In           (shiftSel),
      .SC_FROGREGISTER_matrix_Out                  (matrix),
      .SC_FROGREGISTER_row_Out                     (row),
      .SC_FROGREGISTER_col_Out                     (col),
      .SC_FROGREGISTER_bottomsidecomparator_OutLow (bottom),
      .SC_FROGREGISTER_goal_OutHigh                (goal),
      .SC_FROGREGISTER_hops_Out                    (hops)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle command, then back to idle (inputs change 1 ns after the edge).
   task automatic cmd(input logic c, input logic l0, input logic l1, input logic [1:0] sh);
      clearN   = c;
      load0N   = l0;
      load1N   = l1;
      shiftSel = sh;
      tick();
      clearN   = 1'b1;
      load0N   = 1'b1;
      load1N   = 1'b1;
      shiftSel = 2'b11;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rstN     = 1'b0;
      clearN   = 1'b1;
      load0N   = 1'b1;
      load1N   = 1'b1;
      shiftSel = 2'b11;
      #23 rstN = 1'b1;
      tick();

      check("rst_row",    64'(row),    64'd0);
      check("rst_col",    64'(col),    64'd3);
      check("rst_matrix", matrix,      64'h0000_0000_0000_0008);
      check("rst_bottom", 64'(bottom), 64'd0);
      check("rst_hops",   64'(hops),   64'd0);
      check("rst_goal",   64'(goal),   64'd0);

      // Climb to the top row; goal pulses only after the seventh step.
      for (int i = 1; i <= 7; i++) begin
         cmd(1'b1, 1'b0, 1'b1, 2'b11);
         check("up_row",  64'(row),  64'(i));
         check("up_goal", 64'(goal), (i == 7) ? 64'd1 : 64'd0);
      end
      check("top_matrix", matrix, 64'h0800_0000_0000_0000);
      check("top_bottom", 64'(bottom), 64'd1);
      tick();
      check("goal_one_cycle", 64'(goal), 64'd0);
      check("up7_hops",       64'(hops), 64'd7);
      cmd(1'b1, 1'b0, 1'b1, 2'b11);
      check("up8_row",  64'(row),  64'd7);
      check("up8_hops", 64'(hops), 64'd7);
      check("up8_goal", 64'(goal), 64'd0);

      // Left to column 7, then one blocked left.
      for (int i = 0; i < 4; i++) cmd(1'b1, 1'b1, 1'b1, 2'b01);
      check("left_col",  64'(col),  64'd7);
      check("left_hops", 64'(hops), 64'd11);
      check("left_matrix", matrix, 64'h8000_0000_0000_0000);
      cmd(1'b1, 1'b1, 1'b1, 2'b01);
      check("left_edge_col",  64'(col),  64'd7);
      check("left_edge_hops", 64'(hops), 64'd11);

      // Right edge: walk to column 0 and try once more.
      for (int i = 0; i < 8; i++) cmd(1'b1, 1'b1, 1'b1, 2'b10);
      check("right_edge_col",  64'(col),  64'd0);
      check("right_edge_hops", 64'(hops), 64'd18);

      // Clear, then a blocked down at the bottom row.
      cmd(1'b0, 1'b1, 1'b1, 2'b11);
      check("clear_row",  64'(row),  64'd0);
      check("clear_col",  64'(col),  64'd3);
      check("clear_hops", 64'(hops), 64'd0);
      cmd(1'b1, 1'b1, 1'b0, 2'b11);
      check("down_edge_row",    64'(row),    64'd0);
      check("down_edge_bottom", 64'(bottom), 64'd0);
      check("down_edge_hops",   64'(hops),   64'd0);

      // Down from row 2 to row 1 is accepted.
      cmd(1'b1, 1'b0, 1'b1, 2'b11);
      cmd(1'b1, 1'b0, 1'b1, 2'b11);
      cmd(1'b1, 1'b1, 1'b0, 2'b11);
      check("down_row",  64'(row),  64'd1);
      check("down_hops", 64'(hops), 64'd3);

      // Priority: reach row 4, col 5, then clear+up+left together.
      cmd(1'b0, 1'b1, 1'b1, 2'b11);
      for (int i = 0; i < 4; i++) cmd(1'b1, 1'b0, 1'b1, 2'b11);
      cmd(1'b1, 1'b1, 1'b1, 2'b01);
      cmd(1'b1, 1'b1, 1'b1, 2'b01);
      check("pre_prio_matrix", matrix, 64'h0000_0020_0000_0000);
      cmd(1'b0, 1'b0, 1'b1, 2'b01);
      check("prio_clear_row",  64'(row),  64'd0);
      check("prio_clear_col",  64'(col),  64'd3);
      check("prio_clear_hops", 64'(hops), 64'd0);
      cmd(1'b1, 1'b0, 1'b0, 2'b11);
      check("prio_up_row",  64'(row),  64'd1);
      check("prio_up_hops", 64'(hops), 64'd1);
      // Down beats shift.
      cmd(1'b1, 1'b1, 1'b0, 2'b01);
      check("prio_down_row", 64'(row), 64'd0);
      check("prio_down_col", 64'(col), 64'd3);

      // Saturation: 300 alternating left/right pulses separated by shift=00.
      cmd(1'b0, 1'b1, 1'b1, 2'b11);
      for (int i = 0; i < 300; i++) begin
         cmd(1'b1, 1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
         if (i == 253) check("sat_hops_254", 64'(hops), 64'd254);
         if (i == 298) check("sat_odd_col",  64'(col),  64'd4);
         cmd(1'b1, 1'b1, 1'b1, 2'b00);
      end
      check("sat_col",  64'(col),  64'd3);
      check("sat_hops", 64'(hops), 64'd255);
      cmd(1'b1, 1'b1, 1'b1, 2'b00);
      check("hold00_col",  64'(col),  64'd3);
      check("hold00_hops", 64'(hops), 64'd255);

      // Async reset from row 5, col 6, hops 20.
      cmd(1'b0, 1'b1, 1'b1, 2'b11);
      for (int i = 0; i < 5; i++) cmd(1'b1, 1'b0, 1'b1, 2'b11);
      for (int i = 0; i < 3; i++) cmd(1'b1, 1'b1, 1'b1, 2'b01);
      for (int i = 0; i < 6; i++) begin
         cmd(1'b1, 1'b1, 1'b1, 2'b10);
         cmd(1'b1, 1'b1, 1'b1, 2'b01);
      end
      check("pre_rst_matrix", matrix, 64'h0000_4000_0000_0000);
      check("pre_rst_hops",   64'(hops), 64'd20);
      #2 rstN = 1'b0;
      #1;
      check("async_row",    64'(row),    64'd0);
      check("async_col",    64'(col),    64'd3);
      check("async_matrix", matrix,      64'h0000_0000_0000_0008);
      check("async_bottom", 64'(bottom), 64'd0);
      check("async_hops",   64'(hops),   64'd0);
      check("async_goal",   64'(goal),   64'd0);
      // Release mid-cycle with an up command waiting for the first edge.
      tick();
      load0N = 1'b0;
      #2 rstN = 1'b1;
      tick();
      load0N = 1'b1;
      check("post_rst_row",  64'(row),  64'd1);
      check("post_rst_hops", 64'(hops), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
